sudoku_grid_tx: RTL and testbench
=================================

SUDOKU_GRID_TX -- requirements
Module: sudoku_grid_tx

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter GAP_CYCLES, default 0: idle cycles the block SHALL insert between consecutive cells (range 0..255).
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: single-cycle request to capture a grid and begin transmission.
REQ-006 Port grid, input, 324: packed grid; cell i = row*9+col occupies grid[4*i+3:4*i], value 0 = blank, 1..9 = digit.
REQ-007 Port busy, output, 1: high from capture until the last cell handshakes.
REQ-008 Port out_valid, output, 1: out_data, out_row, out_col, out_last and out_err hold a valid cell.
REQ-009 Port out_ready, input, 1: downstream accepts the cell when high with out_valid.
REQ-010 Port out_data, output, 8: cell payload (encoding per REQ-030/031).
REQ-011 Port out_row, output, 4, and out_col, output, 4: cell coordinates 0..8.
REQ-012 Port out_last, output, 1: high with cell 80 only.
REQ-013 Port out_err, output, 1: high when the current cell's 4-bit value exceeds 9.
REQ-014 Port done, output, 1: one-cycle pulse after cell 80 handshakes.

Function
REQ-015 States SHALL be IDLE, SEND and GAP.
REQ-016 In IDLE, start high SHALL capture grid into an internal 324-bit register and enter SEND on the next edge, with busy high from that edge.
REQ-017 start SHALL be ignored while busy is high; grid changes after capture SHALL not affect the output.
REQ-018 In SEND, out_valid SHALL be high and out_* SHALL reflect the current cell index; the index starts at 0.
REQ-019 out_* SHALL remain stable while out_valid is high and out_ready is low.
REQ-020 A handshake (out_valid and out_ready both high on an edge) SHALL advance the index by one, with col wrapping 8->0 and row incrementing.
REQ-021 After a handshake on cells 0..79, the block SHALL re-enter SEND if GAP_CYCLES = 0 (out_valid stays high, back-to-back transfer at one cell per cycle), else enter GAP.
REQ-022 GAP SHALL hold out_valid low for exactly GAP_CYCLES cycles, then return to SEND.
REQ-023 The handshake on cell 80 SHALL return to IDLE, drop busy and out_valid, and pulse done high for the following cycle.
REQ-024 start asserted in the same cycle done is high SHALL be accepted (IDLE is already active).
REQ-025 Latency from start to first out_valid SHALL be one cycle; a full grid with out_ready held high SHALL take 81 + 80*GAP_CYCLES cycles of out_valid/GAP.
REQ-026 out_err SHALL not stall transmission; cells with values 10..15 SHALL still be sent.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, index 0, and busy, out_valid, out_last, out_err and done to 0.
REQ-028 On reset, out_data, out_row and out_col SHALL be 0, and the capture register SHALL be cleared.
REQ-029 Reset during SEND or GAP SHALL abandon the grid; no done pulse SHALL follow.

Configuration
REQ-030 Without SUDOKU_ASCII_EN, out_data SHALL be {4'h0, value}.
REQ-031 With SUDOKU_ASCII_EN, out_data SHALL be 8'h30+value for 1..9, 8'h2E ('.') for 0, and 8'h3F ('?') for 10..15.

Structure
REQ-032 Shared package sudoku_pkg SHALL hold GRID_N=9, CELLS=81, CELL_W=4, GRID_W=324 and the state enumeration.
REQ-033 A sub-module sudoku_cell_enc SHALL implement the value-to-out_data mapping and the out_err compare.

Verification
REQ-034 Reset, grid with cell i = (i%9)+1, one start pulse, out_ready=1 -> 81 back-to-back cells, cell 10 is row1/col1 with data 2, out_last on cell 80, then done.
REQ-035 GAP_CYCLES=3, same grid -> 3 low-valid cycles between every pair of cells; 81+240 cycles from first valid to last handshake.
REQ-036 out_ready toggling pseudo-randomly -> no cell dropped or repeated, and out_* stable during stalls.
REQ-037 Grid cell 5 = 4'hC and cell 6 = 0 -> out_err high on cell 5 only; with SUDOKU_ASCII_EN, data is 8'h3F and 8'h2E; without it, data is 8'h0C and 8'h00.
REQ-038 rst_n low at cell 40 -> out_valid low immediately, no done; a new start afterwards restarts at cell 0.
REQ-039 start reasserted mid-transfer with a different grid -> ignored; start in the done cycle -> new grid captured.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared sizes and FSM encoding for the sudoku grid transmitter.
// Cell i = row*9+col occupies grid[4*i+3:4*i].
package sudoku_pkg;

    localparam int GRID_N   = 9;
    localparam int CELLS    = 81;
    localparam int CELL_W   = 4;
    localparam int GRID_W   = 324;
    localparam int IDX_W    = 7;
    localparam int DATA_W   = 8;
    localparam int LAST_IDX = CELLS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/sudoku_cell_enc.sv
// Maps a 4-bit cell value to the output byte and flags values above 9 (combinational).
// SUDOKU_ASCII_EN selects ASCII ('1'..'9', '.', '?') instead of the zero-extended nibble.
module sudoku_cell_enc
    import sudoku_pkg::*;
(
    input  logic [CELL_W-1:0] i_value,
    output logic [DATA_W-1:0] o_data,
    output logic              o_err
);

    logic w_err;

    assign w_err = (i_value > 4'd9);
    assign o_err = w_err;

`ifdef SUDOKU_ASCII_EN
    always_comb begin
        o_data = 8'h30 + {4'h0, i_value};
        if (i_value == 4'd0) begin
            o_data = 8'h2E;
        end else if (w_err) begin
            o_data = 8'h3F;
        end
    end
`else
    assign o_data = {4'h0, i_value};
`endif

endmodule

// File: rtl/sudoku_grid_tx.sv
// Captures an 81-cell grid on start and streams it cell by cell; first valid 1 cycle after start.
// Holds out_* while out_ready is low; optional GAP_CYCLES idle cycles between cells; SUDOKU_ASCII_EN selects ASCII payload.
module sudoku_grid_tx
    import sudoku_pkg::*;
#(
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GRID_W-1:0] grid,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        out_row,
    output logic [3:0]        out_col,
    output logic              out_last,
    output logic              out_err,
    output logic              done
);

    localparam logic [7:0] GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t            r_state;
    state_t            w_next_state;
    logic [GRID_W-1:0] r_grid;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        r_row;
    logic [3:0]        r_col;
    logic [7:0]        r_gap_cnt;
    logic              r_done;

    logic              w_capture;
    logic              w_hs;
    logic              w_last;
    logic [CELL_W-1:0] w_cell_val;
    logic [DATA_W-1:0] w_enc_data;
    logic              w_enc_err;

    assign w_last     = (r_idx == IDX_W'(LAST_IDX));
    assign w_hs       = (r_state == ST_SEND) && out_ready;
    assign w_cell_val = r_grid[{r_idx, 2'b00} +: CELL_W];

    sudoku_cell_enc u_enc (
        .i_value (w_cell_val),
        .o_data  (w_enc_data),
        .o_err   (w_enc_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (w_last) begin
                        w_next_state = ST_IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        w_next_state = ST_SEND;
                    end else begin
                        w_next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 8'd0) begin
                    w_next_state = ST_SEND;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Row/col are kept as counters alongside the flat index to avoid a divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grid    <= '0;
            r_idx     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_gap_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_capture) begin
                r_grid <= grid;
                r_idx  <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if (w_hs) begin
                if (w_last) begin
                    r_idx <= '0;
                    r_row <= '0;
                    r_col <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    if (r_col == 4'(GRID_N - 1)) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
            end
            if (w_hs && !w_last) begin
                r_gap_cnt <= GAP_INIT;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 8'd0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_SEND);
    assign out_data  = out_valid ? w_enc_data : '0;
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_last  = out_valid && w_last;
    assign out_err   = out_valid && w_enc_err;
    assign done      = r_done;

endmodule

// File: tb/tb_sudoku_grid_tx.sv
// Bench for sudoku_grid_tx: one instance with GAP_CYCLES=0 and one with GAP_CYCLES=3.
module tb_sudoku_grid_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [323:0] grid;
    logic         start0, start3, ready0, ready3;
    logic         busy0, valid0, last0, err0, done0;
    logic         busy3, valid3, last3, err3, done3;
    logic [7:0]   data0, data3;
    logic [3:0]   row0, col0, row3, col3;
    bit           rnd = 1'b0;

    always #5 clk = ~clk;

    sudoku_grid_tx #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .grid(grid), .busy(busy0),
        .out_valid(valid0), .out_ready(ready0), .out_data(data0), .out_row(row0),
        .out_col(col0), .out_last(last0), .out_err(err0), .done(done0)
    );

    sudoku_grid_tx #(.GAP_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .grid(grid), .busy(busy3),
        .out_valid(valid3), .out_ready(ready3), .out_data(data3), .out_row(row3),
        .out_col(col3), .out_last(last3), .out_err(err3), .done(done3)
    );

`ifdef SUDOKU_ASCII_EN
    localparam logic [7:0] D0 = 8'h31, D5 = 8'h3F, D6 = 8'h2E, D10 = 8'h32, D40 = 8'h35, D80 = 8'h39;
`else
    localparam logic [7:0] D0 = 8'h01, D5 = 8'h0C, D6 = 8'h00, D10 = 8'h02, D40 = 8'h05, D80 = 8'h09;
`endif

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic [3:0] row;
        logic [3:0] col;
        logic       last;
        logic       err;
    } vec_t;

    vec_t tbl [6];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [7:0] enc(input logic [3:0] v);
`ifdef SUDOKU_ASCII_EN
        if (v == 4'd0) return 8'h2E;
        if (v > 4'd9) return 8'h3F;
        return 8'h30 + {4'h0, v};
`else
        return {4'h0, v};
`endif
    endfunction

    function automatic logic [17:0] cell_exp(input logic [323:0] g, input int i);
        logic [3:0] v;
        v = g[4*i +: 4];
        return {enc(v), 4'(i / 9), 4'(i % 9), (i == 80), (v > 4'd9)};
    endfunction

    logic [17:0] sbq [$];

    task automatic push_grid(input logic [323:0] g);
        for (int i = 0; i < 81; i++) sbq.push_back(cell_exp(g, i));
    endtask

    // Scoreboard monitor for the GAP_CYCLES=0 instance
    logic [17:0] rx [0:80];
    int          rx_n = 0;
    int          v0_cnt = 0;
    int          done0_cnt = 0;
    bit          stall_prev = 1'b0;
    logic [17:0] prev_cell;
    logic [17:0] exp_cell;
    wire  [17:0] cur0 = {data0, row0, col0, last0, err0};

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                chk("stall_hold", {valid0, 13'b0, cur0}, {1'b1, 13'b0, prev_cell});
            if (valid0) v0_cnt++;
            if (done0) done0_cnt++;
            if (valid0 && ready0) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_cell: got 0x%0h expected no cell", cur0);
                end else begin
                    exp_cell = sbq.pop_front();
                    chk("cell", 32'(cur0), 32'(exp_cell));
                end
                if (rx_n < 81) rx[rx_n] = cur0;
                rx_n++;
            end
            stall_prev = valid0 && !ready0;
            prev_cell  = cur0;
        end
    end

    // Timing monitor for the GAP_CYCLES=3 instance
    int span3 = 0, v3_cnt = 0, run3 = 0, run_min = 1000, run_max = 0, done3_cnt = 0;
    bit act3 = 1'b0, seen3 = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid3 && !seen3) begin
                act3  = 1'b1;
                seen3 = 1'b1;
            end
            if (act3) begin
                span3++;
                if (valid3) begin
                    v3_cnt++;
                    if (run3 > 0) begin
                        if (run3 < run_min) run_min = run3;
                        if (run3 > run_max) run_max = run3;
                        run3 = 0;
                    end
                    if (ready3 && last3) act3 = 1'b0;
                end else begin
                    run3++;
                end
            end
            if (done3) done3_cnt++;
        end
    end

    initial begin
        ready0 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ready0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_done0(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done0) seen = 1'b1;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start0();
        @(posedge clk);
        #1 start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    logic [323:0] g_a, g_b, g_c, g_d;
    bit           found;
    bit           seen3_done;
    int           d_snap;

    initial begin
        tbl[0] = '{0,  D0,  4'd0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{5,  D5,  4'd0, 4'd5, 1'b0, 1'b1};
        tbl[2] = '{6,  D6,  4'd0, 4'd6, 1'b0, 1'b0};
        tbl[3] = '{10, D10, 4'd1, 4'd1, 1'b0, 1'b0};
        tbl[4] = '{40, D40, 4'd4, 4'd4, 1'b0, 1'b0};
        tbl[5] = '{80, D80, 4'd8, 4'd8, 1'b1, 1'b0};

        grid   = '0;
        start0 = 1'b0;
        start3 = 1'b0;
        ready3 = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_last", 32'(last0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_data", 32'(data0), 0);
        chk("rst_rowcol", 32'({row0, col0}), 0);
        chk("rst_valid3", 32'(valid3), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full grid, back-to-back on dut0 and gapped on dut3
        for (int i = 0; i < 81; i++) g_a[4*i +: 4] = 4'((i % 9) + 1);
        g_a[4*5 +: 4] = 4'hC;
        g_a[4*6 +: 4] = 4'h0;
        grid = g_a;
        rx_n = 0;
        v0_cnt = 0;
        push_grid(g_a);
        @(posedge clk);
        #1 start0 = 1'b1;
        start3 = 1'b1;
        chk("pre_start_valid", 32'(valid0), 0);
        @(posedge clk);
        #1 start0 = 1'b0;
        start3 = 1'b0;
        chk("first_valid", 32'(valid0), 1);
        chk("first_busy", 32'(busy0), 1);
        grid = ~g_a;
        wait_done0(300, "doneA_seen");
        chk("doneA_busy_low", 32'(busy0), 0);
        chk("doneA_valid_low", 32'(valid0), 0);
        @(posedge clk);
        #1 chk("done_one_cycle", 32'(done0), 0);
        chk("sbA_drained", 32'(sbq.size()), 0);
        chk("validA_cycles", 32'(v0_cnt), 81);
        chk("rxA_count", 32'(rx_n), 81);
        for (int k = 0; k < 6; k++)
            chk($sformatf("tbl_cell%0d", tbl[k].idx), 32'(rx[tbl[k].idx]),
                32'({tbl[k].data, tbl[k].row, tbl[k].col, tbl[k].last, tbl[k].err}));

        seen3_done = 1'b0;
        for (int c = 0; c < 600 && !seen3_done; c++) begin
            @(posedge clk);
            #1;
            if (done3_cnt > 0) seen3_done = 1'b1;
        end
        chk("gap_done_seen", 32'(seen3_done), 1);
        chk("gap_span", 32'(span3), 321);
        chk("gap_valid_cycles", 32'(v3_cnt), 81);
        chk("gap_run_min", 32'(run_min), 3);
        chk("gap_run_max", 32'(run_max), 3);
        chk("gap_done_count", 32'(done3_cnt), 1);

        // Reset while cell 40 is presented
        grid = g_a;
        push_grid(g_a);
        pulse_start0();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk);
            #1;
            if (valid0 && row0 == 4'd4 && col0 == 4'd4) found = 1'b1;
        end
        chk("reach_cell40", 32'(found), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst40_valid", 32'(valid0), 0);
        chk("rst40_busy", 32'(busy0), 0);
        chk("rst40_rowcol", 32'({row0, col0}), 0);
        sbq.delete();
        d_snap = done0_cnt;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("rst40_no_done", 32'(done0_cnt - d_snap), 0);

        // Random backpressure, ignored mid-transfer start, start in done cycle
        for (int i = 0; i < 81; i++) begin
            g_b[4*i +: 4] = 4'($urandom_range(0, 15));
            g_c[4*i +: 4] = 4'($urandom_range(0, 15));
            g_d[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        grid = g_b;
        push_grid(g_b);
        rnd = 1'b1;
        pulse_start0();
        repeat (30) @(posedge clk);
        #1 chk("mid_busy", 32'(busy0), 1);
        grid = g_c;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        wait_done0(2000, "doneB_seen");
        grid = g_d;
        start0 = 1'b1;
        push_grid(g_d);
        @(posedge clk);
        #1 start0 = 1'b0;
        chk("restart_in_done_busy", 32'(busy0), 1);
        wait_done0(2000, "doneD_seen");
        rnd = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("sb_final_drained", 32'(sbq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
